// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-macro signals shared by the port arbiter.
// slave is the arbiter's view; master is the core/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [1:0]            d_size;
  logic                  d_unsigned;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_unsigned, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_size, mem_unsigned
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store ports onto one fixed-latency memory, one access in
// flight, data-priority with a starvation override for fetch, misaligned data trapped.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;

  state_e     state_q, state_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       owner_q, owner_d;  // 1 = data port owns the outstanding access
  logic       store_q, store_d;

  logic done, grant_window, contended, force_fetch;
  logic gnt_d, gnt_f, d_misaligned;

  assign done         = (state_q == BUSY) && (lat_cnt_q == 4'd0);
  assign grant_window = !rst && ((state_q == IDLE) || done);
  assign contended    = bus.if_req && bus.d_req;
  assign force_fetch  = contended && (starve_cnt_q == 4'(STARVE_LIMIT));
  assign gnt_d        = grant_window && bus.d_req && !force_fetch;
  assign gnt_f        = grant_window && bus.if_req && !gnt_d;

  always_comb begin
    case (bus.d_size)
      2'b00:   d_misaligned = 1'b0;
      2'b01:   d_misaligned = bus.d_addr[0];
      2'b10:   d_misaligned = (bus.d_addr[1:0] != 2'b00);
      default: d_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= 4'd0;
      starve_cnt_q <= 4'd0;
      owner_q      <= 1'b0;
      store_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    owner_d      = owner_q;
    store_d      = store_q;
    starve_cnt_d = starve_cnt_q;

    // Only a data grant that beat a waiting fetch counts toward starvation.
    if (!bus.if_req || gnt_f) begin
      starve_cnt_d = 4'd0;
    end else if (gnt_d && contended) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    case (state_q)
      BUSY: begin
        if (lat_cnt_q != 4'd0) lat_cnt_d = lat_cnt_q - 4'd1;
        else                   state_d   = IDLE;
      end
      ERR:     state_d = IDLE;
      default: state_d = state_q;
    endcase

    if (gnt_d && d_misaligned) begin
      state_d = ERR;
      owner_d = 1'b1;
      store_d = 1'b0;
    end else if (gnt_d || gnt_f) begin
      state_d   = BUSY;
      lat_cnt_d = 4'(MEM_LATENCY - 1);
      owner_d   = gnt_d;
      store_d   = gnt_d && bus.d_we;
    end
  end

  always_comb begin
    bus.if_gnt       = 1'b0;
    bus.if_rvalid    = 1'b0;
    bus.if_rdata     = {DATA_WIDTH{1'b0}};
    bus.d_gnt        = 1'b0;
    bus.d_rvalid     = 1'b0;
    bus.d_rdata      = {DATA_WIDTH{1'b0}};
    bus.d_err        = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = {ADDR_WIDTH{1'b0}};
    bus.mem_wdata    = {DATA_WIDTH{1'b0}};
    bus.mem_size     = 2'b00;
    bus.mem_unsigned = 1'b0;

    if (!rst) begin
      bus.if_gnt = gnt_f;
      bus.d_gnt  = gnt_d;
      if (gnt_f) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.if_addr;
        bus.mem_size = 2'b10;
      end else if (gnt_d && !d_misaligned) begin
        bus.mem_en       = 1'b1;
        bus.mem_we       = bus.d_we;
        bus.mem_addr     = bus.d_addr;
        bus.mem_wdata    = bus.d_wdata;
        bus.mem_size     = bus.d_size;
        bus.mem_unsigned = bus.d_unsigned;
      end

      if (done && !owner_q) begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end
      if (done && owner_q) begin
        bus.d_rvalid = 1'b1;
        if (!store_q) bus.d_rdata = bus.mem_rdata;
      end
      if (state_q == ERR) begin
        bus.d_rvalid = 1'b1;
        bus.d_err    = 1'b1;
      end
    end
  end

endmodule
